// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [1:0]  DATA_TO_REG_LOAD = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is master, the controller is slave.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_written_reg;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        dmem_ready;
  logic        pc_ce;
  logic        if_id_ce;
  logic        if_id_flush;
  logic        id_ex_ce;
  logic        id_ex_flush;
  logic        ex_mem_ce;
  logic        mem_wb_ce;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_written_reg,
           ex_mem_read, ex_branch_taken, mem_req, dmem_ready,
    input  pc_ce, if_id_ce, if_id_flush, id_ex_ce, id_ex_flush,
           ex_mem_ce, mem_wb_ce, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_written_reg,
           ex_mem_read, ex_branch_taken, mem_req, dmem_ready,
    output pc_ce, if_id_ce, if_id_flush, id_ex_ce, id_ex_flush,
           ex_mem_ce, mem_wb_ce, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_written_reg_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_written_reg_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_written_reg_i);

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign load_use_o = ex_mem_read_i && (ex_written_reg_i != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline CE/flush sequencer: memory-wait FSM with timeout, branch flush, load-use bubble.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic wait_release;
  logic dwait_cond;
  logic pc_ce, if_id_ce, if_id_flush, id_ex_ce, id_ex_flush, ex_mem_ce, mem_wb_ce;

  hazard_detect u_hazard_detect (
    .id_rs1_i         (bus.id_rs1),
    .id_rs2_i         (bus.id_rs2),
    .id_use_rs1_i     (bus.id_use_rs1),
    .id_use_rs2_i     (bus.id_use_rs2),
    .ex_written_reg_i (bus.ex_written_reg),
    .ex_mem_read_i    (bus.ex_mem_read),
    .load_use_o       (load_use)
  );

  // On timeout the stuck access is released for one cycle as if it had completed.
  assign wait_release = (state_q == DWAIT) && (wait_cnt_q == CNT_W'(WAIT_MAX));
  assign dwait_cond   = bus.mem_req && !bus.dmem_ready && !wait_release;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q || wait_release;

    unique case (state_q)
      RUN:     if (dwait_cond)  state_d = DWAIT;
      DWAIT:   if (!dwait_cond) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (dwait_cond) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_comb begin
    pc_ce       = 1'b0;
    if_id_ce    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_ce    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_ce   = 1'b0;
    mem_wb_ce   = 1'b0;

    if (!rst || dwait_cond) begin
      // hold everything: in reset, or waiting on data memory
    end else if (bus.ex_branch_taken) begin
      // squashes the ID instruction too, which is why it outranks load-use
      {pc_ce, if_id_ce, id_ex_ce, ex_mem_ce, mem_wb_ce} = '1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      id_ex_ce    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_ce   = 1'b1;
      mem_wb_ce   = 1'b1;
    end else begin
      {pc_ce, if_id_ce, id_ex_ce, ex_mem_ce, mem_wb_ce} = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bus.pc_ce       = pc_ce;
  assign bus.if_id_ce    = if_id_ce;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_ce    = id_ex_ce;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_ce   = ex_mem_ce;
  assign bus.mem_wb_ce   = mem_wb_ce;
  assign bus.mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_ce && (stall_cycles_q != '1))                     stall_cycles_d = stall_cycles_q + 1'b1;
    if ((if_id_flush || id_ex_flush) && (flush_count_q != '1)) flush_count_d  = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = 32'h0;
  assign bus.flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX=15).
module tb_pipe_hazard_ctrl;

  localparam int WAIT_MAX = 15;

  // {pc_ce, if_id_ce, if_id_flush, id_ex_ce, id_ex_flush, ex_mem_ce, mem_wb_ce}
  localparam logic [6:0] O_HOLD   = 7'b000_0000;
  localparam logic [6:0] O_RUN    = 7'b110_1011;
  localparam logic [6:0] O_BRANCH = 7'b111_1111;
  localparam logic [6:0] O_LDUSE  = 7'b000_1111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if ifc ();

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {ifc.pc_ce, ifc.if_id_ce, ifc.if_id_flush, ifc.id_ex_ce,
            ifc.id_ex_flush, ifc.ex_mem_ce, ifc.mem_wb_ce};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.id_rs1          = 5'd0;
    ifc.id_rs2          = 5'd0;
    ifc.id_use_rs1      = 1'b0;
    ifc.id_use_rs2      = 1'b0;
    ifc.ex_written_reg  = 5'd0;
    ifc.ex_mem_read     = 1'b0;
    ifc.ex_branch_taken = 1'b0;
    ifc.mem_req         = 1'b0;
    ifc.dmem_ready      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (outs() !== O_HOLD) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), O_HOLD);
    end
    checks++;
    if (ifc.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout: got %b expected 0", ifc.mem_timeout);
    end
    checks++;
    if (ifc.stall_cycles !== 32'h0 || ifc.flush_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", ifc.stall_cycles, ifc.flush_count);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL after_reset_run: got %b expected %b", outs(), O_RUN);
    end
  endtask

  task automatic test_load_use();
    tick();
    ifc.ex_mem_read = 1'b1; ifc.ex_written_reg = 5'd5;
    ifc.id_rs1 = 5'd5; ifc.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== O_LDUSE) begin
      errors++;
      $display("FAIL load_use_rs1: got %b expected %b", outs(), O_LDUSE);
    end
    // load has advanced to MEM; EX now holds the bubble
    tick();
    ifc.ex_mem_read = 1'b0; ifc.ex_written_reg = 5'd0;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL load_use_next: got %b expected %b", outs(), O_RUN);
    end
    tick();
    idle_inputs();
    ifc.ex_mem_read = 1'b1; ifc.ex_written_reg = 5'd9;
    ifc.id_rs2 = 5'd9; ifc.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (outs() !== O_LDUSE) begin
      errors++;
      $display("FAIL load_use_rs2: got %b expected %b", outs(), O_LDUSE);
    end
    tick();
    ifc.id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL rs2_not_used: got %b expected %b", outs(), O_RUN);
    end
    tick();
    idle_inputs();
    ifc.ex_mem_read = 1'b1; ifc.ex_written_reg = 5'd0;
    ifc.id_rs1 = 5'd0; ifc.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL load_to_x0: got %b expected %b", outs(), O_RUN);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch();
    logic [31:0] base;
    tick();
    base = ifc.flush_count;
    ifc.ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs() !== O_BRANCH) begin
      errors++;
      $display("FAIL branch_flush: got %b expected %b", outs(), O_BRANCH);
    end
    tick();
    ifc.ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL branch_one_cycle: got %b expected %b", outs(), O_RUN);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (ifc.flush_count - base !== 32'd1) begin
      errors++;
      $display("FAIL flush_count_delta: got %0d expected 1", ifc.flush_count - base);
    end
`else
    checks++;
    if (ifc.flush_count !== 32'h0 || base !== 32'h0) begin
      errors++;
      $display("FAIL flush_count_tied: got %0d expected 0", ifc.flush_count);
    end
`endif
    // branch and load-use together: branch wins
    tick();
    ifc.ex_branch_taken = 1'b1;
    ifc.ex_mem_read = 1'b1; ifc.ex_written_reg = 5'd3;
    ifc.id_rs1 = 5'd3; ifc.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== O_BRANCH) begin
      errors++;
      $display("FAIL branch_over_load_use: got %b expected %b", outs(), O_BRANCH);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    tick();
    ifc.mem_req = 1'b1; ifc.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs() !== O_HOLD) begin
        errors++;
        $display("FAIL mem_wait_hold[%0d]: got %b expected %b", i, outs(), O_HOLD);
      end
      tick();
    end
    ifc.dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== O_RUN || ifc.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_exit: got %b/%b expected %b/0", outs(), ifc.mem_timeout, O_RUN);
    end
    // branch held through a wait is applied on the exit cycle
    tick();
    ifc.dmem_ready = 1'b0; ifc.ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs() !== O_HOLD) begin
        errors++;
        $display("FAIL wait_branch_hold[%0d]: got %b expected %b", i, outs(), O_HOLD);
      end
      tick();
    end
    ifc.dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== O_BRANCH) begin
      errors++;
      $display("FAIL wait_branch_exit: got %b expected %b", outs(), O_BRANCH);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout_reset();
    logic [31:0] base;
    tick();
    base = ifc.stall_cycles;
    ifc.mem_req = 1'b1; ifc.dmem_ready = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      #1;
      checks++;
      if (outs() !== O_HOLD || ifc.mem_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: got %b/%b expected %b/0", i, outs(), ifc.mem_timeout, O_HOLD);
      end
      tick();
    end
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL timeout_release: got %b expected %b", outs(), O_RUN);
    end
    tick();
    #1;
    checks++;
    if (ifc.mem_timeout !== 1'b1 || outs() !== O_HOLD) begin
      errors++;
      $display("FAIL timeout_flag: got %b/%b expected 1/%b", ifc.mem_timeout, outs(), O_HOLD);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (ifc.stall_cycles - base !== 32'd15) begin
      errors++;
      $display("FAIL stall_cycles_delta: got %0d expected 15", ifc.stall_cycles - base);
    end
`else
    checks++;
    if (ifc.stall_cycles !== 32'h0 || base !== 32'h0) begin
      errors++;
      $display("FAIL stall_cycles_tied: got %0d expected 0", ifc.stall_cycles);
    end
`endif
    tick();
    #1;
    checks++;
    if (ifc.mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", ifc.mem_timeout);
    end
    // asynchronous reset in the middle of a wait
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== O_HOLD || ifc.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b/%b expected %b/0", outs(), ifc.mem_timeout, O_HOLD);
    end
    checks++;
    if (ifc.stall_cycles !== 32'h0 || ifc.flush_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait_counters: got %0d/%0d expected 0/0", ifc.stall_cycles, ifc.flush_count);
    end
    tick();
    rst = 1'b1;
    // wait counter restarted from 0: release must come after a full WAIT_MAX again
    for (int i = 0; i < WAIT_MAX; i++) begin
      #1;
      checks++;
      if (outs() !== O_HOLD) begin
        errors++;
        $display("FAIL rewait_hold[%0d]: got %b expected %b", i, outs(), O_HOLD);
      end
      tick();
    end
    #1;
    checks++;
    if (outs() !== O_RUN || ifc.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rewait_release: got %b/%b expected %b/0", outs(), ifc.mem_timeout, O_RUN);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
